dn_cnt_win: RTL and testbench
=============================

DN_CNT_WIN -- requirements
Module: dn_cnt_win

Interface
REQ-001 Parameter N, default 12, sets the width of the count and of the load value.
REQ-002 Parameter MARGIN, default 50, sets the early-warning count value.
REQ-003 clk  input  1  Single clock; all state changes on its rising edge.
REQ-004 rst  input  1  Synchronous reset, active-high.
REQ-005 start  input  1  Request to load load_val and begin a countdown window.
REQ-006 load_val  input  N  Window length in enabled cycles, unsigned.
REQ-007 cen  input  1  Count enable; one decrement per enabled cycle while running.
REQ-008 abort  input  1  Terminates a running window without signalling done.
REQ-009 Out  output  N  Current remaining count (registered).
REQ-010 cntf  output  1  Early flag; high while running and Out == MARGIN.
REQ-011 done  output  1  Single-cycle window-complete pulse.
REQ-012 busy  output  1  High while a window is running.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE with start=1 and load_val!=0 SHALL load Out<=load_val and go to RUN at that edge.
REQ-015 IDLE with start=1 and load_val==0 SHALL set Out<=0 and go directly to DONE.
REQ-016 IDLE with start=0 SHALL hold Out and stay in IDLE.
REQ-017 RUN with abort=1 SHALL set Out<=0 and go to IDLE, with no done pulse; abort overrides cen.
REQ-018 RUN with abort=0, cen=1 and Out>1 SHALL decrement Out by 1.
REQ-019 RUN with abort=0, cen=1 and Out==1 SHALL set Out<=0 and go to DONE.
REQ-020 RUN with cen=0 and abort=0 SHALL hold Out and state.
REQ-021 start SHALL be ignored in RUN and in DONE; no reload and no restart.
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE with Out held at 0.
REQ-023 abort SHALL be ignored in IDLE and in DONE.
REQ-024 Out SHALL never underflow; arithmetic is N-bit unsigned with no wrap below 0.
REQ-025 done SHALL be a combinational decode of state==DONE: high for exactly one cycle per completed window.
REQ-026 busy SHALL be a combinational decode of state==RUN.
REQ-027 cntf SHALL equal (state==RUN) AND (Out == MARGIN), compared at N bits.
REQ-028 cntf SHALL be high on the first RUN cycle when load_val == MARGIN.
REQ-029 cntf SHALL never assert when MARGIN==0 or MARGIN >= 2^N.
REQ-030 cntf SHALL stay high for as long as cen=0 holds Out at MARGIN.
REQ-031 A window of load_val=L with cen held high SHALL assert done exactly L edges after the start edge.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, Out=0, done=0, busy=0 and cntf=0.
REQ-033 rst SHALL take priority over start, cen and abort in every state, including mid-window.
REQ-034 After reset is released, the first start SHALL behave per REQ-014 and REQ-015 with no residual state.

Verification
REQ-035 The bench SHALL cover a basic countdown:
- Stimulus: load_val=5; start pulsed at edge 0; cen held 1.
- Response: Out=5,4,3,2,1 with busy=1; Out=0 and done=1 after edge 5; IDLE after edge 6.
REQ-036 The bench SHALL cover the early flag:
- Stimulus: MARGIN=50; load_val=60; cen held 1.
- Response: cntf high exactly one cycle, after edge 10 (Out=50); done after edge 60.
REQ-037 The bench SHALL cover cen gaps:
- Stimulus: load_val=4; cen pattern 1,0,0,1,1,1.
- Response: Out=4,3,3,3,2,1,0; done after the 6th enabled-pattern edge; no extra decrements.
REQ-038 The bench SHALL cover abort with a simultaneous start:
- Stimulus: abort=1 and start=1 asserted while Out=3.
- Response: Out=0, state IDLE, busy=0, done never asserts, start ignored.
REQ-039 The bench SHALL cover a zero-length window:
- Stimulus: start with load_val=0.
- Response: done=1 for one cycle after the start edge, busy never asserts, Out=0.
REQ-040 The bench SHALL cover reset mid-window:
- Stimulus: rst=1 for one edge while Out=7 in RUN with cen=1.
- Response: Out=0, busy=0, done=0; a following start with load_val=2 completes in 2 enabled edges.

Source files
------------

// File: rtl/dn_cnt_win.sv
// dn_cnt_win: loadable down-counting window timer.
//
// A window is opened by start in IDLE; the counter then decrements once per
// enabled (cen) cycle until it reaches zero, at which point done pulses for
// one cycle. abort closes a running window silently. An early-warning flag
// (cntf) marks the cycles where the running count sits at MARGIN.
//
// Handshake: there is no valid/ready pair. start is a level request that is
// sampled only in IDLE (ignored while RUN or DONE). done is a one-cycle
// completion strobe. busy is high for the whole running window.
//
// Ports:
//   clk       in   clock, all state changes on rising edge
//   rst       in   synchronous active-high reset, highest priority
//   start     in   open a window with length load_val
//   load_val  in   [N-1:0] window length in enabled cycles
//   cen       in   count enable while running
//   abort     in   close a running window without done
//   Out       out  [N-1:0] remaining count (registered)
//   cntf      out  running and Out == MARGIN
//   done      out  one-cycle completion pulse (state DONE)
//   busy      out  window running (state RUN)
//   dbg_state out  [1:0] FSM state: 0 IDLE, 1 RUN, 2 DONE
module dn_cnt_win #(
  parameter int N      = 12,
  parameter int MARGIN = 50
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] load_val,
  input  logic         cen,
  input  logic         abort,
  output logic [N-1:0] Out,
  output logic         cntf,
  output logic         done,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // MARGIN values that cannot be represented in N bits (or zero) must never
  // raise cntf, so they are disabled here rather than truncated.
  localparam bit MARGIN_OK =
    (MARGIN > 0) && (longint'(MARGIN) < (longint'(1) << N));
  localparam logic [N-1:0] MARGIN_N = MARGIN_OK ? N'(MARGIN) : '0;
  localparam logic [N-1:0] ONE      = N'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      Out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (load_val != '0) begin
              Out   <= load_val;
              state <= RUN;
            end else begin
              Out   <= '0;
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (abort) begin
            Out   <= '0;
            state <= IDLE;
          end else if (cen) begin
            if (Out > ONE) begin
              Out <= Out - ONE;
            end else begin
              // Out==1 is the last enabled cycle; clamping also guards
              // against any underflow below zero.
              Out   <= '0;
              state <= DONE;
            end
          end
        end
        DONE: begin
          Out   <= '0;
          state <= IDLE;
        end
        default: begin
          Out   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign done      = (state == DONE);
  assign busy      = (state == RUN);
  assign cntf      = MARGIN_OK && (state == RUN) && (Out == MARGIN_N);
  assign dbg_state = state;

endmodule

// File: tb/tb_dn_cnt_win.sv
module tb_dn_cnt_win;
  localparam int N = 12;
  localparam int MARGIN = 50;
  localparam int W = 2 + N + 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // clock / reset
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] load_val = '0;
  logic         cen = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] Out;
  logic         cntf;
  logic         done;
  logic         busy;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  dn_cnt_win #(.N(N), .MARGIN(MARGIN)) dut (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val), .cen(cen),
    .abort(abort), .Out(Out), .cntf(cntf), .done(done), .busy(busy),
    .dbg_state(dbg_state)
  );

  // scoreboard: {state, Out, cntf, done, busy}
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_pass = 0;

  // driver: drive inputs for the next edge and queue the expected result
  task automatic step(input logic s, input logic [N-1:0] lv, input logic c,
                      input logic a, input logic r, input logic [1:0] es,
                      input logic [N-1:0] eo, input logic ecf, input string nm);
    @(negedge clk);
    start = s; load_val = lv; cen = c; abort = a; rst = r;
    exp_q.push_back({es, eo, ecf, (es == S_DONE), (es == S_RUN)});
    name_q.push_back(nm);
  endtask

  // monitor: one output sample per edge, compared against the queue head
  initial begin
    logic [W-1:0] exp_w;
    logic [W-1:0] got_w;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        nm = name_q.pop_front();
        got_w = {dbg_state, Out, cntf, done, busy};
        n_checks++;
        if (got_w === exp_w) n_pass++;
        else
          $display("FAIL %s: got st=%0d out=%0d cntf=%b done=%b busy=%b, want st=%0d out=%0d cntf=%b done=%b busy=%b",
                   nm, got_w[W-1 -: 2], got_w[N+2:3], got_w[2], got_w[1], got_w[0],
                   exp_w[W-1 -: 2], exp_w[N+2:3], exp_w[2], exp_w[1], exp_w[0]);
      end
    end
  end

  initial begin
    int k;
    // reset dominates every other input
    step(1, 12'd9, 1, 1, 1, S_IDLE, 0, 0, "reset");
    step(1, 12'd9, 1, 1, 1, S_IDLE, 0, 0, "reset_hold");
    step(0, 12'd0, 0, 1, 0, S_IDLE, 0, 0, "idle_abort_ignored");
    step(0, 12'd7, 1, 0, 0, S_IDLE, 0, 0, "idle_hold");

    // basic countdown, start ignored mid-run and in DONE
    step(1, 12'd5, 1, 0, 0, S_RUN, 5, 0, "basic_load");
    for (int i = 1; i <= 4; i++)
      step((i == 2), 12'd9, 1, 0, 0, S_RUN, N'(5 - i), 0, "basic_dec");
    step(0, 12'd0, 1, 0, 0, S_DONE, 0, 0, "basic_done");
    step(1, 12'd3, 1, 0, 0, S_IDLE, 0, 0, "basic_done_start_ignored");
    step(0, 12'd0, 0, 0, 0, S_IDLE, 0, 0, "basic_idle");

    // early flag over a 60-cycle window
    step(1, 12'd60, 1, 0, 0, S_RUN, 60, 0, "flag_load");
    for (int i = 1; i <= 59; i++)
      step(0, 12'd0, 1, 0, 0, S_RUN, N'(60 - i), (60 - i == 50), "flag_dec");
    step(0, 12'd0, 1, 0, 0, S_DONE, 0, 0, "flag_done");
    step(0, 12'd0, 0, 0, 0, S_IDLE, 0, 0, "flag_idle");

    // load_val == MARGIN: flag on first RUN cycle, held while cen=0
    step(1, 12'd50, 0, 0, 0, S_RUN, 50, 1, "flag_first");
    for (int i = 0; i < 3; i++)
      step(0, 12'd0, 0, 0, 0, S_RUN, 50, 1, "flag_hold");
    step(0, 12'd0, 1, 0, 0, S_RUN, 49, 0, "flag_leave");
    step(0, 12'd0, 1, 1, 0, S_IDLE, 0, 0, "flag_abort");

    // cen gaps: pattern 1,0,0,1,1,1
    step(1, 12'd4, 0, 0, 0, S_RUN, 4, 0, "gap_load");
    step(0, 12'd0, 1, 0, 0, S_RUN, 3, 0, "gap_e1");
    step(0, 12'd0, 0, 0, 0, S_RUN, 3, 0, "gap_e2");
    step(0, 12'd0, 0, 0, 0, S_RUN, 3, 0, "gap_e3");
    step(0, 12'd0, 1, 0, 0, S_RUN, 2, 0, "gap_e4");
    step(0, 12'd0, 1, 0, 0, S_RUN, 1, 0, "gap_e5");
    step(0, 12'd0, 1, 0, 0, S_DONE, 0, 0, "gap_done");
    step(0, 12'd0, 0, 0, 0, S_IDLE, 0, 0, "gap_idle");

    // abort with simultaneous start at Out=3
    step(1, 12'd5, 1, 0, 0, S_RUN, 5, 0, "abort_load");
    step(0, 12'd0, 1, 0, 0, S_RUN, 4, 0, "abort_dec4");
    step(0, 12'd0, 1, 0, 0, S_RUN, 3, 0, "abort_dec3");
    step(1, 12'd9, 1, 1, 0, S_IDLE, 0, 0, "abort_hit");
    step(0, 12'd0, 1, 0, 0, S_IDLE, 0, 0, "abort_no_done");

    // zero-length window, abort ignored in DONE
    step(1, 12'd0, 1, 0, 0, S_DONE, 0, 0, "zero_done");
    step(1, 12'd6, 0, 1, 0, S_IDLE, 0, 0, "zero_idle");
    step(0, 12'd0, 0, 0, 0, S_IDLE, 0, 0, "zero_stay");

    // one-cycle window
    step(1, 12'd1, 0, 0, 0, S_RUN, 1, 0, "one_load");
    step(0, 12'd0, 1, 0, 0, S_DONE, 0, 0, "one_done");
    step(0, 12'd0, 0, 0, 0, S_IDLE, 0, 0, "one_idle");

    // full-scale load value then abort
    step(1, 12'hFFF, 1, 0, 0, S_RUN, 12'hFFF, 0, "max_load");
    step(0, 12'd0, 1, 0, 0, S_RUN, 12'hFFE, 0, "max_dec");
    step(0, 12'd0, 0, 1, 0, S_IDLE, 0, 0, "max_abort");

    // reset mid-window at Out=7, then clean 2-cycle window
    step(1, 12'd9, 1, 0, 0, S_RUN, 9, 0, "rst_load");
    step(0, 12'd0, 1, 0, 0, S_RUN, 8, 0, "rst_dec8");
    step(0, 12'd0, 1, 0, 0, S_RUN, 7, 0, "rst_dec7");
    step(1, 12'd3, 1, 0, 1, S_IDLE, 0, 0, "rst_mid");
    step(1, 12'd2, 1, 0, 0, S_RUN, 2, 0, "rst_after_load");
    step(0, 12'd0, 1, 0, 0, S_RUN, 1, 0, "rst_after_dec");
    step(0, 12'd0, 1, 0, 0, S_DONE, 0, 0, "rst_after_done");
    step(0, 12'd0, 0, 0, 0, S_IDLE, 0, 0, "rst_after_idle");

    // drain the scoreboard with a bounded wait
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
